// File: rtl/button_ctrl_pkg.sv
// Shared types and default timing constants for the push-button controller.
// Cycle counts assume the 12 MHz board clock.
package button_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } press_state_t;

  localparam int DEBOUNCE_1MS_12M  = 12000;
  localparam int LONG_PRESS_1S_12M = 12000000;
  localparam int LED_100MS_12M     = 1200000;

endpackage

// File: rtl/button_ctrl_debouncer.sv
// Two-flop synchronizer plus stable-time debouncer for the raw button.
// The level flips only after the synchronized input differs for DEBOUNCE_CYCLES.
module btn_debouncer
  import button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_12M
) (
  input  logic clk_12m,
  input  logic rst,
  input  logic btn_raw,
  output logic level
);

  localparam int TW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          btn_s;
  logic [TW-1:0] tmr;

  always_ff @(posedge clk_12m) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
      tmr   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      btn_s <= sync1;
      if (btn_s == level) begin
        tmr <= '0;
      end else if (tmr == T_LAST) begin
        tmr   <= '0;
        level <= ~level;
      end else begin
        tmr <= tmr + TW'(1);
      end
    end
  end

endmodule

// File: rtl/button_press_ctrl.sv
// Short/long press classifier driving an event counter and a stretched LED.
// Short press increments the counter, long press clears it.
module button_press_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_1MS_12M,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_1S_12M,
  parameter int LED_PULSE_CYCLES  = LED_100MS_12M,
  parameter int CNT_W             = 8
) (
  input  logic             clk_12m,
  input  logic             rst,
  input  logic             btn,
  output logic             pressed,
  output logic             inc_pulse,
  output logic             clr_pulse,
  output logic [CNT_W-1:0] count,
  output logic             led
);

  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int LW = $clog2(LED_PULSE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [LW-1:0] LED_LOAD  = LW'(LED_PULSE_CYCLES);

  press_state_t     state, state_nxt;
  logic [HW-1:0]    hold, hold_nxt;
  logic [LW-1:0]    led_tmr;
  logic [CNT_W-1:0] count_nxt;
  logic             inc_nxt, clr_nxt;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk_12m(clk_12m),
    .rst    (rst),
    .btn_raw(btn),
    .level  (pressed)
  );

  // Hold time counts from the cycle pressed rises, so the
  // clear strobe lands LONG_PRESS_CYCLES after that edge.
  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    count_nxt = count;
    inc_nxt   = 1'b0;
    clr_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt = PRESSED;
          hold_nxt  = HW'(1);
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_nxt = IDLE;
          inc_nxt   = 1'b1;
          count_nxt = count + CNT_W'(1);
        end else if (hold == HOLD_LAST) begin
          state_nxt = HELD;
          clr_nxt   = 1'b1;
          count_nxt = '0;
        end else begin
          hold_nxt = hold + HW'(1);
        end
      end
      HELD: begin
        if (!pressed) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_12m) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      count     <= '0;
      inc_pulse <= 1'b0;
      clr_pulse <= 1'b0;
      led_tmr   <= '0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      count     <= count_nxt;
      inc_pulse <= inc_nxt;
      clr_pulse <= clr_nxt;
      if (inc_nxt || clr_nxt) begin
        led_tmr <= LED_LOAD;
      end else if (led_tmr != '0) begin
        led_tmr <= led_tmr - LW'(1);
      end
    end
  end

  assign led = (led_tmr != '0);

endmodule

// File: tb/tb_button_press_ctrl.sv
// Directed self-checking bench for button_press_ctrl.
// Uses short sim timings: debounce 4, long press 20, LED 8.
module tb_button_press_ctrl;

  logic       clk_12m;
  logic       rst;
  logic       btn;
  logic       pressed;
  logic       inc_pulse;
  logic       clr_pulse;
  logic [7:0] count;
  logic       led;

  int n_cmp = 0;
  int n_err = 0;
  int inc_seen = 0;
  int clr_seen = 0;

  button_press_ctrl #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .LED_PULSE_CYCLES (8),
    .CNT_W            (8)
  ) dut (
    .clk_12m  (clk_12m),
    .rst      (rst),
    .btn      (btn),
    .pressed  (pressed),
    .inc_pulse(inc_pulse),
    .clr_pulse(clr_pulse),
    .count    (count),
    .led      (led)
  );

  initial clk_12m = 1'b0;
  always #5 clk_12m = ~clk_12m;

  always @(posedge clk_12m) begin
    if (inc_pulse) inc_seen <= inc_seen + 1;
    if (clr_pulse) clr_seen <= clr_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_12m);
    #1;
  endtask

  task automatic press(input int h);
    btn = 1'b1;
    tick(h);
    btn = 1'b0;
    tick(10);
  endtask

  task automatic led_run(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (!led) break;
      n++;
    end
  endtask

  task automatic long_press(input string t);
    int c0;
    int i0;
    c0 = clr_seen;
    i0 = inc_seen;
    btn = 1'b1;
    tick(6);
    chk({t, "_rise"}, 32'(pressed), 32'd1);
    tick(19);
    chk({t, "_clr_early"}, 32'(clr_pulse), 32'd0);
    tick(1);
    chk({t, "_clr"}, 32'(clr_pulse), 32'd1);
    chk({t, "_cnt0"}, 32'(count), 32'd0);
    tick(14);
    btn = 1'b0;
    tick(12);
    chk({t, "_clr_once"}, 32'(clr_seen - c0), 32'd1);
    chk({t, "_no_inc"}, 32'(inc_seen - i0), 32'd0);
  endtask

  initial begin
    int n;
    int i0;
    int c0;
    logic rose;

    btn = 1'b0;
    rst = 1'b1;
    tick(3);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_inc", 32'(inc_pulse), 32'd0);
    chk("rst_clr", 32'(clr_pulse), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    rst = 1'b0;
    tick(2);

    // bounce shorter than the debounce window
    i0 = inc_seen;
    c0 = clr_seen;
    rose = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn = ((i / 2) % 2 == 0);
      tick(1);
      if (pressed) rose = 1'b1;
    end
    btn = 1'b0;
    tick(10);
    chk("t2_no_rise", 32'(rose), 32'd0);
    chk("t2_no_inc", 32'(inc_seen - i0), 32'd0);
    chk("t2_no_clr", 32'(clr_seen - c0), 32'd0);
    chk("t2_count", 32'(count), 32'd0);

    // clean 10-cycle short press
    btn = 1'b1;
    tick(5);
    chk("t1_pre_rise", 32'(pressed), 32'd0);
    tick(1);
    chk("t1_rise", 32'(pressed), 32'd1);
    tick(4);
    btn = 1'b0;
    tick(6);
    chk("t1_fall", 32'(pressed), 32'd0);
    chk("t1_inc_early", 32'(inc_pulse), 32'd0);
    tick(1);
    chk("t1_inc", 32'(inc_pulse), 32'd1);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_led_on", 32'(led), 32'd1);
    tick(1);
    chk("t1_inc_1cyc", 32'(inc_pulse), 32'd0);
    led_run(n);
    chk("t1_led_len", 32'(n + 2), 32'd8);

    long_press("t3a");
    repeat (5) press(8);
    chk("t3_count5", 32'(count), 32'd5);
    long_press("t3b");

    // release exactly at hold = 19: release wins
    i0 = inc_seen;
    c0 = clr_seen;
    btn = 1'b1;
    tick(19);
    btn = 1'b0;
    tick(12);
    chk("t5_rel_inc", 32'(inc_seen - i0), 32'd1);
    chk("t5_rel_noclr", 32'(clr_seen - c0), 32'd0);
    chk("t5_rel_count", 32'(count), 32'd1);

    // second command lands as the first stretch would expire
    btn = 1'b1;
    tick(8);
    btn = 1'b0;
    tick(4);
    btn = 1'b1;
    tick(3);
    chk("t5_inc1", 32'(inc_pulse), 32'd1);
    tick(1);
    btn = 1'b0;
    tick(7);
    chk("t5_inc2", 32'(inc_pulse), 32'd1);
    chk("t5_led_held", 32'(led), 32'd1);
    chk("t5_count", 32'(count), 32'd3);
    led_run(n);
    chk("t5_led_reload", 32'(n), 32'd7);

    // reset in the middle of a press
    i0 = inc_seen;
    btn = 1'b1;
    tick(8);
    chk("t6_pre_pressed", 32'(pressed), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("t6_pressed", 32'(pressed), 32'd0);
    chk("t6_inc", 32'(inc_pulse), 32'd0);
    chk("t6_clr", 32'(clr_pulse), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_led", 32'(led), 32'd0);
    rst = 1'b0;
    tick(5);
    chk("t6_pre_rerise", 32'(pressed), 32'd0);
    tick(1);
    chk("t6_rerise", 32'(pressed), 32'd1);
    btn = 1'b0;
    tick(12);
    chk("t6_count1", 32'(count), 32'd1);
    chk("t6_one_inc", 32'(inc_seen - i0), 32'd1);

    // 256 presses wrap the counter back to 0
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    i0 = inc_seen;
    for (int i = 1; i <= 256; i++) begin
      press(8);
      chk("t4_wrap", 32'(count), 32'(i % 256));
    end
    chk("t4_inc_total", 32'(inc_seen - i0), 32'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
